spmv_pe_sequencer: RTL and testbench

//  Drives op_in of one spmv_pe through the full SpMV bring-up and run: PE reset, delta-code load,

---
 rtl/spmv_pe_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_spmv_pe_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_pe_sequencer.sv
// spmv_pe_sequencer
// Drives the op port of one spmv_pe through PE reset, the three code-table
// loads (delta, prefix, common double), register setup and OP_STEADY. Every
// opcode is issued for one cycle. The PE busy output is the phase-complete
// handshake. Header pointers are captured when a start is accepted.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               1-cycle start pulse, accepted only in IDLE
//   i_hdr_*               SMAC header fields (64 bit), sampled at accepted start
//   o_op_out              registered opcode word to spmv_pe op_in
//   i_pe_busy             spmv_pe busy_out
//   o_seq_busy            high while a sequence is in progress
//   o_done                1-cycle pulse when the steady-state phase completes
//   o_error               sticky watchdog error, cleared by the next accepted start
//
// Op word layout: opcode in [ARG_PE-1:0], PE id in [ARG_1-1:ARG_PE],
// register index in [ARG_2-1:ARG_1], value in [63:ARG_2] (truncated).
// Field positions and opcode values mirror spmv_opcodes.vh and are exposed
// as parameters so they can track that header.
module spmv_pe_sequencer #(
    parameter int         PE_ID              = 0,
    parameter int         RST_CYCLES         = 10,
    parameter int         SETTLE_CYCLES      = 10,
    parameter int         TIMEOUT_W          = 24,
    parameter int         OPCODE_ARG_PE      = 8,
    parameter int         OPCODE_ARG_1       = 16,
    parameter int         OPCODE_ARG_2       = 24,
    parameter logic [7:0] OP_NOP             = 8'h00,
    parameter logic [7:0] OP_RST             = 8'h01,
    parameter logic [7:0] OP_LD              = 8'h02,
    parameter logic [7:0] OP_LD_DELTA_CODES  = 8'h03,
    parameter logic [7:0] OP_LD_PREFIX_CODES = 8'h04,
    parameter logic [7:0] OP_LD_COMMON_CODES = 8'h05,
    parameter logic [7:0] OP_STEADY          = 8'h06
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [63:0] i_hdr_width,
    input  logic [63:0] i_hdr_height,
    input  logic [63:0] i_hdr_nnz,
    input  logic [63:0] i_hdr_spm_codes,
    input  logic [63:0] i_hdr_fzip_codes,
    input  logic [63:0] i_hdr_common_dbl,
    input  logic [63:0] i_hdr_spm_cs,
    input  logic [63:0] i_hdr_spm_as,
    input  logic [63:0] i_hdr_fzip_cs,
    input  logic [63:0] i_hdr_fzip_as,
    input  logic [63:0] i_hdr_size,
    output logic [63:0] o_op_out,
    input  logic        i_pe_busy,
    output logic        o_seq_busy,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_GAP, S_ISSUE, S_SETTLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {PH_DELTA, PH_PREFIX, PH_COMMON, PH_STEADY} phase_t;

    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    // Watchdog starts at 0 on WAIT entry; expiring at all-ones-minus-one gives
    // exactly 2**TIMEOUT_W-1 busy WAIT cycles.
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [63:0] PE_MASK  = (64'd1 << (OPCODE_ARG_1 - OPCODE_ARG_PE)) - 64'd1;
    localparam logic [63:0] REG_MASK = (64'd1 << (OPCODE_ARG_2 - OPCODE_ARG_1)) - 64'd1;

    function automatic logic [63:0] mk_op(input logic [7:0] opc, input logic [7:0] rix,
                                          input logic [63:0] val);
        return (val << OPCODE_ARG_2)
             | ((64'(rix) & REG_MASK) << OPCODE_ARG_1)
             | ((64'(PE_ID) & PE_MASK) << OPCODE_ARG_PE)
             | 64'(opc);
    endfunction

    state_t                r_state, w_state_nxt;
    phase_t                r_phase, w_phase_nxt;
    logic [15:0]           r_cnt, w_cnt_nxt;
    logic [TIMEOUT_W-1:0]  r_wdog, w_wdog_nxt;
    logic                  r_error, w_error_nxt;
    logic                  r_armed;
    logic [63:0]           r_op, w_op_nxt;

    logic [63:0] r_spm_codes, r_fzip_codes, r_common_dbl;
    logic [63:0] r_spm_cs, r_spm_as, r_fzip_cs, r_fzip_as;
    logic [63:0] r_size, r_nnz_m1, r_y, r_y_end;

    logic        w_accept;
    logic [15:0] w_last;
    logic [7:0]  w_reg, w_opc;
    logic [63:0] w_val, w_a, w_b, w_c;
    logic [7:0]  w_trig;

    // r_armed blocks a start on the first edge after reset release.
    assign w_accept = i_start && r_armed && (r_state == S_IDLE);
    assign w_last   = (r_phase == PH_STEADY) ? 16'd14 : 16'd4;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_wdog_nxt  = r_wdog;
        w_error_nxt = r_error;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_state_nxt = S_RST;
                w_cnt_nxt   = '0;
                w_error_nxt = 1'b0;
            end
            S_RST: if (r_cnt == RST_LAST) begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = '0;
            end else w_cnt_nxt = r_cnt + 16'd1;
            S_GAP: begin
                w_state_nxt = S_ISSUE;
                w_phase_nxt = PH_DELTA;
                w_cnt_nxt   = '0;
            end
            S_ISSUE: if (r_cnt == w_last) begin
                w_state_nxt = S_SETTLE;
                w_cnt_nxt   = '0;
            end else w_cnt_nxt = r_cnt + 16'd1;
            S_SETTLE: if (r_cnt == SETTLE_LAST) begin
                w_state_nxt = S_WAIT;
                w_wdog_nxt  = '0;
            end else w_cnt_nxt = r_cnt + 16'd1;
            S_WAIT: if (!i_pe_busy) begin
                if (r_phase == PH_STEADY) w_state_nxt = S_DONE;
                else begin
                    w_state_nxt = S_ISSUE;
                    w_phase_nxt = phase_t'(r_phase + 2'd1);
                    w_cnt_nxt   = '0;
                end
            end else if (r_wdog == WDOG_LAST) begin
                w_state_nxt = S_IDLE;
                w_error_nxt = 1'b1;
            end else w_wdog_nxt = r_wdog + 1'b1;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase table lookup: entry r_cnt of phase r_phase.
    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_c    = '0;
        w_trig = OP_LD_DELTA_CODES;
        case (r_phase)
            PH_DELTA:  begin w_a = r_spm_codes;  w_b = r_fzip_codes; w_c = 64'd4096;  w_trig = OP_LD_DELTA_CODES;  end
            PH_PREFIX: begin w_a = r_fzip_codes; w_b = r_common_dbl; w_c = 64'd8192;  w_trig = OP_LD_PREFIX_CODES; end
            PH_COMMON: begin w_a = r_common_dbl; w_b = r_spm_cs;     w_c = 64'd65536; w_trig = OP_LD_COMMON_CODES; end
            default:   begin w_a = '0;           w_b = '0;           w_c = '0;        w_trig = OP_STEADY;          end
        endcase
        w_reg = '0;
        w_val = '0;
        w_opc = OP_LD;
        if (r_phase == PH_STEADY) begin
            w_reg = r_cnt[7:0];
            case (r_cnt[3:0])
                4'd0:         w_val = r_y;
                4'd1:         w_val = r_y_end;
                4'd2, 4'd11:  w_val = r_size;
                4'd3, 4'd12,
                4'd13:        w_val = r_nnz_m1;
                4'd4:         w_val = r_spm_cs;
                4'd5, 4'd8:   w_val = r_spm_as;
                4'd6, 4'd9:   w_val = r_fzip_cs;
                4'd7, 4'd10:  w_val = r_fzip_as;
                default: begin w_reg = '0; w_opc = OP_STEADY; end
            endcase
        end else begin
            case (r_cnt[2:0])
                3'd0:    begin w_reg = 8'd4; w_val = w_a; end
                3'd1:    begin w_reg = 8'd8; w_val = w_b; end
                3'd2:    begin w_reg = 8'd5; w_val = '0;  end
                3'd3:    begin w_reg = 8'd9; w_val = w_c; end
                default: begin w_reg = '0;   w_opc = w_trig; end
            endcase
        end
    end

    // op_out is registered from the current state, so it lags the state by a cycle.
    always_comb begin
        w_op_nxt = 64'(OP_NOP);
        case (r_state)
            S_RST:   w_op_nxt = mk_op(OP_RST, 8'd0, 64'd0);
            S_ISSUE: w_op_nxt = mk_op(w_opc, w_reg, w_val);
            default: w_op_nxt = 64'(OP_NOP);
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_phase <= PH_DELTA;
            r_cnt   <= '0;
            r_wdog  <= '0;
            r_error <= 1'b0;
            r_armed <= 1'b0;
            r_op    <= 64'(OP_NOP);
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wdog  <= w_wdog_nxt;
            r_error <= w_error_nxt;
            r_armed <= 1'b1;
            r_op    <= w_op_nxt;
        end
    end

    // Header capture; y and y_end are precomputed so ISSUE only muxes registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_spm_codes  <= '0; r_fzip_codes <= '0; r_common_dbl <= '0;
            r_spm_cs     <= '0; r_spm_as     <= '0; r_fzip_cs    <= '0;
            r_fzip_as    <= '0; r_size       <= '0; r_nnz_m1     <= '0;
            r_y          <= '0; r_y_end      <= '0;
        end else if (w_accept) begin
            r_spm_codes  <= i_hdr_spm_codes;
            r_fzip_codes <= i_hdr_fzip_codes;
            r_common_dbl <= i_hdr_common_dbl;
            r_spm_cs     <= i_hdr_spm_cs;
            r_spm_as     <= i_hdr_spm_as;
            r_fzip_cs    <= i_hdr_fzip_cs;
            r_fzip_as    <= i_hdr_fzip_as;
            r_size       <= i_hdr_size;
            r_nnz_m1     <= i_hdr_nnz - 64'd1;
            r_y          <= i_hdr_size + (i_hdr_width << 3);
            r_y_end      <= i_hdr_size + (i_hdr_width << 3) + (i_hdr_height << 3);
        end
    end

    assign o_op_out   = r_op;
    assign o_seq_busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done     = (r_state == S_DONE);
    assign o_error    = r_error;

endmodule

// File: tb/tb_spmv_pe_sequencer.sv
module tb_spmv_pe_sequencer;

    localparam int         R    = 10;
    localparam int         S    = 10;
    localparam int         TW   = 6;
    localparam logic [7:0] PEID = 8'h3;
    localparam logic [63:0] NOP = 64'h0, RSTOP = 64'h1, LD = 64'h2;
    localparam logic [63:0] TDELTA = 64'h3, TPREF = 64'h4, TCOMM = 64'h5, TSTEADY = 64'h6;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, pe_busy = 1'b0;
    logic [63:0] hdr_width, hdr_height, hdr_nnz, hdr_spm_codes, hdr_fzip_codes, hdr_common_dbl;
    logic [63:0] hdr_spm_cs, hdr_spm_as, hdr_fzip_cs, hdr_fzip_as, hdr_size;
    logic [63:0] op_out;
    logic        seq_busy, done, error;

    int errors = 0, checks = 0;
    logic [63:0] exp_q[$], obs_q[$];
    int done_cnt = 0, act_cnt = 0, pe_mode = 0, busy_left = 0;
    logic err_after_start;
    bit finished;

    always #5 clk = ~clk;

    spmv_pe_sequencer #(.PE_ID(int'(PEID)), .RST_CYCLES(R), .SETTLE_CYCLES(S), .TIMEOUT_W(TW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_hdr_width(hdr_width), .i_hdr_height(hdr_height), .i_hdr_nnz(hdr_nnz),
        .i_hdr_spm_codes(hdr_spm_codes), .i_hdr_fzip_codes(hdr_fzip_codes),
        .i_hdr_common_dbl(hdr_common_dbl), .i_hdr_spm_cs(hdr_spm_cs), .i_hdr_spm_as(hdr_spm_as),
        .i_hdr_fzip_cs(hdr_fzip_cs), .i_hdr_fzip_as(hdr_fzip_as), .i_hdr_size(hdr_size),
        .o_op_out(op_out), .i_pe_busy(pe_busy), .o_seq_busy(seq_busy), .o_done(done),
        .o_error(error));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] mk(input logic [63:0] opc, input int r, input logic [63:0] v);
        return (v << 24) | (64'(r) << 16) | (64'(PEID) << 8) | opc;
    endfunction

    function automatic logic [63:0] obs_val(input int i);
        if (i < obs_q.size()) return obs_q[i] >> 24;
        return '1;
    endfunction

    // Expected non-NOP op stream of one complete run, straight from the phase tables.
    task automatic build_trace();
        logic [63:0] y, ye, n1;
        logic [63:0] sv[14];
        y  = hdr_size + hdr_width * 64'd8;
        ye = y + hdr_height * 64'd8;
        n1 = hdr_nnz - 64'd1;
        exp_q.delete();
        for (int i = 0; i < R; i++) exp_q.push_back(mk(RSTOP, 0, 0));
        exp_q.push_back(mk(LD, 4, hdr_spm_codes));  exp_q.push_back(mk(LD, 8, hdr_fzip_codes));
        exp_q.push_back(mk(LD, 5, 0));              exp_q.push_back(mk(LD, 9, 4096));
        exp_q.push_back(mk(TDELTA, 0, 0));
        exp_q.push_back(mk(LD, 4, hdr_fzip_codes)); exp_q.push_back(mk(LD, 8, hdr_common_dbl));
        exp_q.push_back(mk(LD, 5, 0));              exp_q.push_back(mk(LD, 9, 8192));
        exp_q.push_back(mk(TPREF, 0, 0));
        exp_q.push_back(mk(LD, 4, hdr_common_dbl)); exp_q.push_back(mk(LD, 8, hdr_spm_cs));
        exp_q.push_back(mk(LD, 5, 0));              exp_q.push_back(mk(LD, 9, 65536));
        exp_q.push_back(mk(TCOMM, 0, 0));
        sv = '{y, ye, hdr_size, n1, hdr_spm_cs, hdr_spm_as, hdr_fzip_cs, hdr_fzip_as,
               hdr_spm_as, hdr_fzip_cs, hdr_fzip_as, hdr_size, n1, n1};
        for (int i = 0; i < 14; i++) exp_q.push_back(mk(LD, i, sv[i]));
        exp_q.push_back(mk(TSTEADY, 0, 0));
    endtask

    task automatic set_hdr_t1();
        hdr_width = 8; hdr_height = 8; hdr_nnz = 20; hdr_size = 64'h1000;
        hdr_spm_codes = 64'h100; hdr_fzip_codes = 64'h200; hdr_common_dbl = 64'h300;
        hdr_spm_cs = 64'h400; hdr_spm_as = 64'h500; hdr_fzip_cs = 64'h600; hdr_fzip_as = 64'h700;
    endtask

    // Compare process: every non-NOP op must be the next expected table entry.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (seq_busy || done) act_cnt++;
            if (done) begin
                done_cnt++;
                chk("seq_busy_low_with_done", {63'd0, seq_busy}, 64'd0);
            end
            if (op_out !== NOP) begin
                obs_q.push_back(op_out);
                if (exp_q.size() == 0) chk("extra_op", op_out, NOP);
                else begin
                    e = exp_q.pop_front();
                    chk("op_trace", op_out, e);
                end
            end
        end
    end

    // Behavioural PE: busy for 50 cycles after any trigger (mode 0), never (1), stuck (2).
    initial begin
        forever begin
            @(negedge clk);
            case (pe_mode)
                0: begin
                    pe_busy = (busy_left > 0);
                    if (busy_left > 0) busy_left--;
                    if (op_out[7:0] inside {8'h3, 8'h4, 8'h5, 8'h6}) busy_left = 50;
                end
                1: pe_busy = 1'b0;
                default: pe_busy = 1'b1;
            endcase
        end
    end

    task automatic run_seq(input int budget, input int pulse_at, input int rst_at, input bit scramble);
        int n;
        bit pulsed;
        act_cnt = 0; done_cnt = 0; obs_q.delete();
        build_trace();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        err_after_start = error;
        if (scramble) begin hdr_size = 64'hDEAD_0000; hdr_width = 77; hdr_spm_cs = 64'hBEEF; end
        n = 0; pulsed = 0; finished = 0;
        while (n < budget) begin
            @(negedge clk); n++;
            if (done || (error && !seq_busy)) begin finished = 1; break; end
            if (pulse_at >= 0 && !pulsed && obs_q.size() >= pulse_at) begin
                start = 1'b1; @(negedge clk); start = 1'b0; pulsed = 1; n++;
            end
            if (rst_at >= 0 && obs_q.size() >= rst_at) begin
                rst_n = 1'b0; #1;
                chk("t4_op_nop_in_reset", op_out, NOP);
                chk("t4_seq_busy_in_reset", {63'd0, seq_busy}, 64'd0);
                chk("t4_done_in_reset", {63'd0, done}, 64'd0);
                finished = 1; break;
            end
        end
        if (!finished) chk("run_timeout", 64'(n), 64'(budget + 1));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        set_hdr_t1();
        repeat (3) @(negedge clk);
        chk("reset_op", op_out, NOP);
        chk("reset_seq_busy", {63'd0, seq_busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_error", {63'd0, error}, 64'd0);

        // start on the reset-release edge is ignored
        @(negedge clk); rst_n = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_at_release_ignored", {63'd0, seq_busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("no_ops_after_ignored_start", 64'(obs_q.size()), 64'd0);

        // pin the model with hand-computed values
        build_trace();
        chk("model_r0", exp_q[25] >> 24, 64'h1040);
        chk("model_r1", exp_q[26] >> 24, 64'h1080);
        chk("model_r3", exp_q[28] >> 24, 64'd19);
        chk("model_len", 64'(exp_q.size()), 64'd40);

        // T1
        pe_mode = 0;
        run_seq(3000, -1, -1, 0);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_op_count", 64'(obs_q.size()), 64'd40);
        chk("t1_exp_left", 64'(exp_q.size()), 64'd0);
        chk("t1_r0", obs_val(25), 64'h1040);
        chk("t1_r1", obs_val(26), 64'h1080);
        chk("t1_r3", obs_val(28), 64'd19);
        chk("t1_idle", {63'd0, seq_busy}, 64'd0);

        // T2: fixed cycle count with pe_busy never asserted
        pe_mode = 1;
        run_seq(3000, -1, -1, 0);
        chk("t2_cycles", 64'(act_cnt), 64'(R + 1 + 4 * (5 + S + 1) + 10 + 1));
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);
        chk("t2_exp_left", 64'(exp_q.size()), 64'd0);

        // T3: re-start mid-PREFIX, header changed after start
        pe_mode = 0;
        run_seq(3000, R + 7, -1, 1);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);
        chk("t3_op_count", 64'(obs_q.size()), 64'd40);
        chk("t3_exp_left", 64'(exp_q.size()), 64'd0);
        chk("t3_r0", obs_val(25), 64'h1040);
        set_hdr_t1();

        // T4: reset during STEADY issue, then a fresh run
        run_seq(3000, -1, R + 18, 0);
        chk("t4_no_done", 64'(done_cnt), 64'd0);
        chk("t4_idle", {63'd0, seq_busy}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_seq(3000, -1, -1, 0);
        chk("t4_rerun_done", 64'(done_cnt), 64'd1);
        chk("t4_rerun_ops", 64'(obs_q.size()), 64'd40);
        chk("t4_rerun_exp_left", 64'(exp_q.size()), 64'd0);

        // T5: watchdog with pe_busy stuck high
        pe_mode = 2;
        run_seq(1000, -1, -1, 0);
        chk("t5_error", {63'd0, error}, 64'd1);
        chk("t5_idle", {63'd0, seq_busy}, 64'd0);
        chk("t5_no_done", 64'(done_cnt), 64'd0);
        chk("t5_cycles", 64'(act_cnt), 64'(R + 1 + 5 + S + 63));
        chk("t5_op_count", 64'(obs_q.size()), 64'd15);
        chk("t5_op_nop", op_out, NOP);
        pe_mode = 0;
        busy_left = 0;
        run_seq(3000, -1, -1, 0);
        chk("t5_error_cleared", {63'd0, err_after_start}, 64'd0);
        chk("t5_rerun_done", 64'(done_cnt), 64'd1);
        chk("t5_rerun_error", {63'd0, error}, 64'd0);

        // T6: y wraps past 2**64
        hdr_size = 64'hFFFF_FFFF_FFFF_FFF8; hdr_width = 1; hdr_height = 8;
        pe_mode = 1;
        run_seq(3000, -1, -1, 0);
        chk("t6_y_wrap", obs_val(25), 64'h0);
        chk("t6_y_end", obs_val(26), 64'h40);
        chk("t6_size_trunc", obs_val(27), 64'hFF_FFFF_FFF8);
        chk("t6_exp_left", 64'(exp_q.size()), 64'd0);
        chk("t6_done_cnt", 64'(done_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
